tick_bcd_stopwatch: RTL and testbench

//  Downstream consumer of the clock-divider stage: takes the divider's slow square

---
 rtl/tick_bcd_stopwatch_if.sv | 36 +++
 rtl/tick_bcd_stopwatch.sv | 149 ++++++++++++++
 tb/tb_tick_bcd_stopwatch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/tick_bcd_stopwatch_if.sv
// Control inputs and BCD count outputs between the stopwatch and its driver.
// The lap signal exists only when LAP_BCD_HOLD_EN is defined.
interface tick_bcd_stopwatch_if #(
  parameter int DIGITS = 4
);
  logic                  lohi;
  logic                  start_stop;
  logic                  clear;
`ifdef LAP_BCD_HOLD_EN
  logic                  lap;
`endif
  logic [4*DIGITS-1:0]   count_bcd;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  running;
  logic                  wrap;

`ifdef LAP_BCD_HOLD_EN
  modport master (
    output lohi, start_stop, clear, lap,
    input  count_bcd, disp_bcd, running, wrap
  );
  modport slave (
    input  lohi, start_stop, clear, lap,
    output count_bcd, disp_bcd, running, wrap
  );
`else
  modport master (
    output lohi, start_stop, clear,
    input  count_bcd, disp_bcd, running, wrap
  );
  modport slave (
    input  lohi, start_stop, clear,
    output count_bcd, disp_bcd, running, wrap
  );
`endif
endinterface

// File: rtl/tick_bcd_stopwatch.sv
// Packed-BCD stopwatch counting divider ticks; LAP_BCD_HOLD_EN adds a lap-hold display freeze.
// Count updates on the edge that first samples lohi high; no backpressure, every tick in RUN is taken.
module tick_bcd_stopwatch #(
  parameter int DIGITS    = 4,
  parameter int EDGE_BOTH = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  tick_bcd_stopwatch_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e              state_q;
  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_d;
  logic                running_q;
  logic                wrap_q;
  logic                lohi_q;
  logic                ss_q;
  logic                tick;
  logic                ss_edge;
  logic                carry;
  logic                all_nines;

`ifdef LAP_BCD_HOLD_EN
  logic                lap_q;
  logic                lap_edge;
  logic                hold_q;
  logic [4*DIGITS-1:0] lap_reg_q;

  assign lap_edge = bus.lap & ~lap_q;
`endif

  assign tick    = (EDGE_BOTH != 0) ? (bus.lohi ^ lohi_q) : (bus.lohi & ~lohi_q);
  assign ss_edge = bus.start_stop & ~ss_q;

  // Ripple BCD increment; carry surviving every digit means the count was all nines.
  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      lohi_q    <= 1'b0;
      ss_q      <= 1'b0;
`ifdef LAP_BCD_HOLD_EN
      lap_q     <= 1'b0;
      hold_q    <= 1'b0;
      lap_reg_q <= '0;
`endif
    end else begin
      lohi_q <= bus.lohi;
      ss_q   <= bus.start_stop;
      wrap_q <= 1'b0;
      if (bus.clear) begin
        state_q   <= IDLE;
        count_q   <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ss_edge) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            // A tick coinciding with the pause request still counts.
            if (tick) begin
              count_q <= count_d;
              wrap_q  <= all_nines;
            end
            if (ss_edge) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end
          end
          PAUSE: begin
            if (ss_edge) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
          end
        endcase
      end
`ifdef LAP_BCD_HOLD_EN
      lap_q <= bus.lap;
      if (bus.clear) begin
        hold_q    <= 1'b0;
        lap_reg_q <= '0;
      end else if (lap_edge && (state_q != IDLE)) begin
        if (hold_q) begin
          hold_q <= 1'b0;
        end else begin
          hold_q    <= 1'b1;
          lap_reg_q <= count_q;
        end
      end
`endif
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.running   = running_q;
  assign bus.wrap      = wrap_q;
`ifdef LAP_BCD_HOLD_EN
  assign bus.disp_bcd  = hold_q ? lap_reg_q : count_q;
`else
  assign bus.disp_bcd  = count_q;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_chk
    a_digit_range: assert property (@(posedge clk) disable iff (reset)
      count_q[4*g +: 4] <= 4'd9);
  end

  a_wrap_zero: assert property (@(posedge clk) disable iff (reset)
    wrap_q |-> (count_q == '0) && running_q);

  a_idle_zero: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> (count_q == '0) && !running_q);

endmodule

// File: tb/tb_tick_bcd_stopwatch.sv
// Directed bench for tick_bcd_stopwatch with hand-computed expected counts.
module tb_tick_bcd_stopwatch;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  tick_bcd_stopwatch_if #(.DIGITS(4)) bus ();

  tick_bcd_stopwatch #(
    .DIGITS   (4),
    .EDGE_BOTH(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rise();
    bus.lohi = 1'b1;
    cyc();
    bus.lohi = 1'b0;
    cyc();
  endtask

  task automatic rises(input int n);
    repeat (n) rise();
  endtask

  task automatic ss_pulse();
    bus.start_stop = 1'b1;
    cyc();
    bus.start_stop = 1'b0;
    cyc();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    cyc();
  endtask

`ifdef LAP_BCD_HOLD_EN
  task automatic lap_pulse();
    bus.lap = 1'b1;
    cyc();
    bus.lap = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.lohi       = 1'b0;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
`ifdef LAP_BCD_HOLD_EN
    bus.lap        = 1'b0;
`endif

    // Reset with lohi toggling, then release with lohi high
    for (int i = 0; i < 3; i++) begin
      bus.lohi = ~bus.lohi;
      cyc();
    end
    check("rst_count",   32'(bus.count_bcd), 32'h0000);
    check("rst_disp",    32'(bus.disp_bcd),  32'h0000);
    check("rst_running", 32'(bus.running),   32'h0);
    check("rst_wrap",    32'(bus.wrap),      32'h0);
    reset = 1'b0;
    cyc();
    check("release_lohi_high", 32'(bus.count_bcd), 32'h0000);
    bus.lohi = 1'b0;
    cyc();
    rises(5);
    check("idle_count",   32'(bus.count_bcd), 32'h0000);
    check("idle_running", 32'(bus.running),   32'h0);

    // Start, then confirm one-cycle latency on the first rise
    ss_pulse();
    check("start_running", 32'(bus.running), 32'h1);
    bus.lohi = 1'b1;
    check("lat_before_edge", 32'(bus.count_bcd), 32'h0000);
    cyc();
    check("lat_after_edge", 32'(bus.count_bcd), 32'h0001);
    bus.lohi = 1'b0;
    cyc();
    rises(11);
    check("count_12", 32'(bus.count_bcd), 32'h0012);
    check("disp_12",  32'(bus.disp_bcd),  32'h0012);

    // Run through digit carries up to all nines, then wrap
    rises(88);
    check("count_100", 32'(bus.count_bcd), 32'h0100);
    rises(9899);
    check("count_9999", 32'(bus.count_bcd), 32'h9999);
    check("wrap_before", 32'(bus.wrap), 32'h0);
    bus.lohi = 1'b1;
    cyc();
    check("wrap_count",   32'(bus.count_bcd), 32'h0000);
    check("wrap_pulse",   32'(bus.wrap),      32'h1);
    check("wrap_running", 32'(bus.running),   32'h1);
    bus.lohi = 1'b0;
    cyc();
    check("wrap_gone", 32'(bus.wrap), 32'h0);
    rise();
    check("after_wrap", 32'(bus.count_bcd), 32'h0001);

    // Pause holds, resume continues
    do_clear();
    check("clear_count",   32'(bus.count_bcd), 32'h0000);
    check("clear_running", 32'(bus.running),   32'h0);
    ss_pulse();
    rises(7);
    check("count_7", 32'(bus.count_bcd), 32'h0007);
    ss_pulse();
    check("pause_running", 32'(bus.running), 32'h0);
    rises(5);
    check("pause_hold", 32'(bus.count_bcd), 32'h0007);
    ss_pulse();
    check("resume_running", 32'(bus.running), 32'h1);
    rises(2);
    check("count_9", 32'(bus.count_bcd), 32'h0009);

    // Tick on RUN->PAUSE counts; tick on PAUSE->RUN does not
    bus.start_stop = 1'b1;
    bus.lohi       = 1'b1;
    cyc();
    check("tick_on_pause",     32'(bus.count_bcd), 32'h0010);
    check("tick_on_pause_run", 32'(bus.running),   32'h0);
    bus.start_stop = 1'b0;
    bus.lohi       = 1'b0;
    cyc();
    bus.start_stop = 1'b1;
    bus.lohi       = 1'b1;
    cyc();
    check("tick_on_resume",     32'(bus.count_bcd), 32'h0010);
    check("tick_on_resume_run", 32'(bus.running),   32'h1);
    bus.start_stop = 1'b0;
    bus.lohi       = 1'b0;
    cyc();
    rise();
    check("count_11", 32'(bus.count_bcd), 32'h0011);

    // Clear beats start_stop and a pending tick
    do_clear();
    ss_pulse();
    rises(30);
    check("count_30", 32'(bus.count_bcd), 32'h0030);
    bus.clear      = 1'b1;
    bus.start_stop = 1'b1;
    bus.lohi       = 1'b1;
    cyc();
    check("clr_ss_count",   32'(bus.count_bcd), 32'h0000);
    check("clr_ss_running", 32'(bus.running),   32'h0);
    bus.clear      = 1'b0;
    bus.start_stop = 1'b0;
    bus.lohi       = 1'b0;
    cyc();
    rise();
    check("clr_then_idle", 32'(bus.count_bcd), 32'h0000);

    // Reset mid-run with a pending tick
    ss_pulse();
    rises(3);
    check("count_3", 32'(bus.count_bcd), 32'h0003);
    reset    = 1'b1;
    bus.lohi = 1'b1;
    cyc();
    check("midrst_count",   32'(bus.count_bcd), 32'h0000);
    check("midrst_running", 32'(bus.running),   32'h0);
    reset    = 1'b0;
    bus.lohi = 1'b0;
    cyc();
    rise();
    check("midrst_idle", 32'(bus.count_bcd), 32'h0000);

`ifdef LAP_BCD_HOLD_EN
    // Lap hold freezes display while counting continues
    do_clear();
    ss_pulse();
    rises(42);
    check("lap_count_42", 32'(bus.count_bcd), 32'h0042);
    lap_pulse();
    rises(3);
    check("lap_disp_held",  32'(bus.disp_bcd),  32'h0042);
    check("lap_count_45",   32'(bus.count_bcd), 32'h0045);
    lap_pulse();
    check("lap_disp_freed", 32'(bus.disp_bcd),  32'h0045);
    lap_pulse();
    do_clear();
    check("lap_clear_disp", 32'(bus.disp_bcd), 32'h0000);
    lap_pulse();
    ss_pulse();
    rises(2);
    check("lap_idle_ignored", 32'(bus.disp_bcd), 32'h0002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
